// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the clock/reset sequencer.
package clk_rst_pkg;

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_FILTER,
        S_RELEASE,
        S_RUN,
        S_FAULT
    } seq_state_t;

    localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/clk_rst_sequencer_lock_sync.sv
// Two-flop synchronizer bringing PLL lock into the SYSCLK domain.
module lock_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            dout <= RST_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/clk_rst_sequencer.sv
// PLL reset/lock sequencer with ordered downstream reset release.
// Define CLK_RST_SEQ_STATS_EN to build the lock-loss counter.
module clk_rst_sequencer
    import clk_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = 200,
    parameter int LOCK_TIMEOUT       = 200000,
    parameter int LOCK_FILTER_CYCLES = 1024,
    parameter int NUM_STAGES         = 3,
    parameter int STAGE_DELAY        = 256,
    parameter int MAX_RETRIES        = 4
) (
    input  logic                  SYSCLK,
    input  logic                  RST,
    input  logic                  PLL_LOCKED,
    output logic                  PLL_RST,
    output logic [NUM_STAGES-1:0] RST_OUT,
    output logic                  READY,
    output logic                  FAULT,
    output logic [LOSS_CNT_W-1:0] LOCK_LOSS_CNT
);

    localparam int RST_W = $clog2(PLL_RST_CYCLES + 1);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int FLT_W = $clog2(LOCK_FILTER_CYCLES + 1);
    localparam int DLY_W = $clog2(STAGE_DELAY + 1);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(LOCK_TIMEOUT);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STAGE_DELAY - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    logic lock_s;

    lock_sync #(.RST_VAL(1'b0)) u_sync (
        .clk  (SYSCLK),
        .rst  (RST),
        .din  (PLL_LOCKED),
        .dout (lock_s)
    );

    seq_state_t              state, state_n;
    logic [RST_W-1:0]        rst_cnt, rst_cnt_n;
    logic [TO_W-1:0]         to_cnt, to_cnt_n, to_inc;
    logic [FLT_W-1:0]        flt_cnt, flt_cnt_n;
    logic [DLY_W-1:0]        dly_cnt, dly_cnt_n;
    logic [RTY_W-1:0]        retry, retry_n;
    logic                    pll_rst_n, ready_n, fault_n;
    logic [NUM_STAGES-1:0]   rst_out_n;
    logic                    lock_loss, start_rel;

    // Timeout keeps counting through filter bounces but must never wrap.
    assign to_inc = (to_cnt == TO_MAX) ? to_cnt : to_cnt + 1'b1;

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            state   <= S_PLL_RST;
            rst_cnt <= '0;
            to_cnt  <= '0;
            flt_cnt <= '0;
            dly_cnt <= '0;
            retry   <= '0;
            PLL_RST <= 1'b1;
            RST_OUT <= '1;
            READY   <= 1'b0;
            FAULT   <= 1'b0;
        end else begin
            state   <= state_n;
            rst_cnt <= rst_cnt_n;
            to_cnt  <= to_cnt_n;
            flt_cnt <= flt_cnt_n;
            dly_cnt <= dly_cnt_n;
            retry   <= retry_n;
            PLL_RST <= pll_rst_n;
            RST_OUT <= rst_out_n;
            READY   <= ready_n;
            FAULT   <= fault_n;
        end
    end

    always_comb begin
        state_n   = state;
        rst_cnt_n = '0;
        to_cnt_n  = to_cnt;
        flt_cnt_n = '0;
        dly_cnt_n = '0;
        retry_n   = retry;
        pll_rst_n = 1'b0;
        rst_out_n = RST_OUT;
        ready_n   = READY;
        fault_n   = 1'b0;
        lock_loss = 1'b0;
        start_rel = 1'b0;

        unique case (state)
            S_PLL_RST: begin
                pll_rst_n = 1'b1;
                rst_out_n = '1;
                ready_n   = 1'b0;
                to_cnt_n  = '0;
                if (rst_cnt == RST_LAST) begin
                    state_n   = S_WAIT_LOCK;
                    pll_rst_n = 1'b0;
                end else begin
                    rst_cnt_n = rst_cnt + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                to_cnt_n = to_inc;
                if (lock_s) begin
                    if (flt_cnt == FLT_LAST) begin
                        start_rel = 1'b1;
                    end else begin
                        state_n   = S_FILTER;
                        flt_cnt_n = flt_cnt + 1'b1;
                    end
                end else if (to_cnt >= TO_LAST) begin
                    retry_n   = retry + 1'b1;
                    to_cnt_n  = '0;
                    pll_rst_n = 1'b1;
                    if (retry_n == RTY_MAX) begin
                        state_n = S_FAULT;
                        fault_n = 1'b1;
                    end else begin
                        state_n = S_PLL_RST;
                    end
                end
            end
            S_FILTER: begin
                to_cnt_n = to_inc;
                if (!lock_s) begin
                    state_n = S_WAIT_LOCK;
                end else if (flt_cnt == FLT_LAST) begin
                    start_rel = 1'b1;
                end else begin
                    flt_cnt_n = flt_cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!lock_s) begin
                    lock_loss = 1'b1;
                end else if (dly_cnt == DLY_LAST) begin
                    // Resets form a thermometer code, so shifting frees the next stage.
                    rst_out_n = RST_OUT << 1;
                    if (rst_out_n == '0) begin
                        ready_n = 1'b1;
                        state_n = S_RUN;
                        retry_n = '0;
                    end
                end else begin
                    dly_cnt_n = dly_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_s) lock_loss = 1'b1;
            end
            S_FAULT: begin
                pll_rst_n = 1'b1;
                rst_out_n = '1;
                ready_n   = 1'b0;
                fault_n   = 1'b1;
            end
            default: begin
                state_n   = S_PLL_RST;
                pll_rst_n = 1'b1;
                rst_out_n = '1;
                ready_n   = 1'b0;
            end
        endcase

        if (start_rel) begin
            rst_out_n    = '1;
            rst_out_n[0] = 1'b0;
            if (NUM_STAGES == 1) begin
                ready_n = 1'b1;
                state_n = S_RUN;
                retry_n = '0;
            end else begin
                state_n = S_RELEASE;
            end
        end

        if (lock_loss) begin
            state_n   = S_PLL_RST;
            pll_rst_n = 1'b1;
            rst_out_n = '1;
            ready_n   = 1'b0;
            retry_n   = '0;
            to_cnt_n  = '0;
        end
    end

`ifdef CLK_RST_SEQ_STATS_EN
    logic [LOSS_CNT_W-1:0] loss_cnt;

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            loss_cnt <= '0;
        end else if (lock_loss && loss_cnt != '1) begin
            loss_cnt <= loss_cnt + 1'b1;
        end
    end

    assign LOCK_LOSS_CNT = loss_cnt;
`else
    assign LOCK_LOSS_CNT = '0;
`endif

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer with small sequencing parameters.
module tb_clk_rst_sequencer;

    logic       SYSCLK = 1'b0;
    logic       RST = 1'b1;
    logic       PLL_LOCKED = 1'b0;
    logic       PLL_RST;
    logic [2:0] RST_OUT;
    logic       READY;
    logic       FAULT;
    logic [7:0] LOCK_LOSS_CNT;

    int checks = 0;
    int failures = 0;

`ifdef CLK_RST_SEQ_STATS_EN
    localparam int EXP_LOSS1 = 1;
    localparam int EXP_SAT   = 255;
`else
    localparam int EXP_LOSS1 = 0;
    localparam int EXP_SAT   = 0;
`endif

    clk_rst_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT       (50),
        .LOCK_FILTER_CYCLES (8),
        .NUM_STAGES         (3),
        .STAGE_DELAY        (5),
        .MAX_RETRIES        (2)
    ) dut (
        .SYSCLK        (SYSCLK),
        .RST           (RST),
        .PLL_LOCKED    (PLL_LOCKED),
        .PLL_RST       (PLL_RST),
        .RST_OUT       (RST_OUT),
        .READY         (READY),
        .FAULT         (FAULT),
        .LOCK_LOSS_CNT (LOCK_LOSS_CNT)
    );

    always #5 SYSCLK = ~SYSCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge SYSCLK);
        #1;
    endtask

    // Leaves the bench just after the last edge that samples RST=1.
    task automatic pulse_rst();
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
    endtask

    task automatic wait_rst0(output bit ok);
        int k = 0;
        while (RST_OUT[0] !== 1'b0 && k < 200) begin
            tick(1);
            k++;
        end
        ok = (RST_OUT[0] === 1'b0);
    endtask

    task automatic wait_ready(output bit ok);
        int k = 0;
        while (READY !== 1'b1 && k < 200) begin
            tick(1);
            k++;
        end
        ok = (READY === 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit bad;

        // reset values
        tick(3);
        chk("rst_pll", PLL_RST, 1);
        chk("rst_out", RST_OUT, 3'b111);
        chk("rst_ready", READY, 0);
        chk("rst_fault", FAULT, 0);
        chk("rst_cnt", LOCK_LOSS_CNT, 0);

        // nominal bring-up, lock rises 20 cycles after reset release
        RST = 1'b0;
        tick(3);
        chk("nom_pll_e3", PLL_RST, 1);
        tick(1);
        chk("nom_pll_e4", PLL_RST, 0);
        tick(16);
        PLL_LOCKED = 1'b1;
        tick(9);
        chk("nom_t9", RST_OUT, 3'b111);
        tick(1);
        chk("nom_t10", RST_OUT, 3'b110);
        tick(4);
        chk("nom_t14", RST_OUT, 3'b110);
        tick(1);
        chk("nom_t15", RST_OUT, 3'b100);
        tick(4);
        chk("nom_t19_rdy", READY, 0);
        tick(1);
        chk("nom_t20", RST_OUT, 3'b000);
        chk("nom_t20_rdy", READY, 1);

        // lock loss while running
        tick(3);
        PLL_LOCKED = 1'b0;
        tick(2);
        chk("run_loss_t2", READY, 1);
        tick(1);
        chk("run_loss_out", RST_OUT, 3'b111);
        chk("run_loss_rdy", READY, 0);
        chk("run_loss_pll", PLL_RST, 1);
        chk("run_loss_cnt", LOCK_LOSS_CNT, EXP_LOSS1);
        PLL_LOCKED = 1'b1;
        wait_ready(ok);
        chk("run_loss_rerun", ok, 1);

        // RST mid-run clears everything, including the loss count
        RST = 1'b1;
        tick(1);
        chk("mid_rst_pll", PLL_RST, 1);
        chk("mid_rst_out", RST_OUT, 3'b111);
        chk("mid_rst_rdy", READY, 0);
        chk("mid_rst_cnt", LOCK_LOSS_CNT, 0);
        RST = 1'b0;

        // lock loss during staged release
        wait_rst0(ok);
        chk("rel_wait", ok, 1);
        PLL_LOCKED = 1'b0;
        tick(2);
        chk("rel_loss_t2", RST_OUT, 3'b110);
        tick(1);
        chk("rel_loss_out", RST_OUT, 3'b111);
        chk("rel_loss_cnt", LOCK_LOSS_CNT, EXP_LOSS1);

        // filter glitch restarts the consecutive-lock count
        pulse_rst();
        tick(4);
        PLL_LOCKED = 1'b1;
        tick(5);
        PLL_LOCKED = 1'b0;
        tick(1);
        PLL_LOCKED = 1'b1;
        tick(9);
        chk("glitch_t9", RST_OUT, 3'b111);
        tick(1);
        chk("glitch_t10", RST_OUT, 3'b110);
        tick(10);
        chk("glitch_t20", RST_OUT, 3'b000);
        chk("glitch_t20_rdy", READY, 1);

        // two lock timeouts lead to a sticky fault
        PLL_LOCKED = 1'b0;
        pulse_rst();
        tick(53);
        chk("to1_e53", PLL_RST, 0);
        tick(1);
        chk("to1_e54", PLL_RST, 1);
        tick(3);
        chk("to1_e57", PLL_RST, 1);
        tick(1);
        chk("to1_e58", PLL_RST, 0);
        tick(49);
        chk("to2_e107", FAULT, 0);
        tick(1);
        chk("to2_fault", FAULT, 1);
        chk("to2_pll", PLL_RST, 1);
        chk("to2_out", RST_OUT, 3'b111);
        PLL_LOCKED = 1'b1;
        tick(30);
        chk("fault_sticky", FAULT, 1);
        chk("fault_rdy", READY, 0);
        RST = 1'b1;
        tick(1);
        chk("fault_clr", FAULT, 0);

        // lock arriving on the timeout cycle wins
        PLL_LOCKED = 1'b0;
        pulse_rst();
        tick(51);
        PLL_LOCKED = 1'b1;
        tick(3);
        chk("tie_pll", PLL_RST, 0);
        tick(7);
        chk("tie_rel", RST_OUT, 3'b110);
        chk("tie_fault", FAULT, 0);

        // 300 lock losses saturate the counter
        pulse_rst();
        bad = 1'b0;
        for (int i = 0; i < 300; i++) begin
            PLL_LOCKED = 1'b1;
            wait_rst0(ok);
            if (!ok) bad = 1'b1;
            PLL_LOCKED = 1'b0;
            tick(3);
        end
        chk("sat_wait", bad, 0);
        chk("sat_cnt", LOCK_LOSS_CNT, EXP_SAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_rst_sequencer.md
# clk_rst_sequencer

Reset and lock sequencer for the board clock PLL. Runs on the PLL-independent 200 MHz SYSCLK. Drives the PLL reset, waits for and filters PLL lock, then releases downstream domain resets in a fixed order. On lock loss it re-runs the whole sequence; after repeated lock timeouts it latches a fault.

## Interface
- PLL_RST_CYCLES, 200: PLL_RST pulse length in SYSCLK cycles.
- LOCK_TIMEOUT, 200000: cycles allowed in S_WAIT_LOCK before a retry (1 ms).
- LOCK_FILTER_CYCLES, 1024: consecutive cycles of synchronized lock required.
- NUM_STAGES, 3: number of downstream reset outputs.
- STAGE_DELAY, 256: cycles between successive stage releases.
- MAX_RETRIES, 4: failed lock attempts before S_FAULT.
- SYSCLK  in  1  sequencer clock, free-running, independent of the PLL.
- RST  in  1  synchronous active-high reset.
- PLL_LOCKED  in  1  PLL lock, asynchronous to SYSCLK.
- PLL_RST  out  1  PLL reset, active-high.
- RST_OUT  out  NUM_STAGES  downstream resets, active-high; bit 0 released first.
- READY  out  1  high when all stages are released and lock is held.
- FAULT  out  1  sticky lock-failure flag.
- LOCK_LOSS_CNT  out  8  saturating count of lock losses in S_RELEASE or S_RUN.

## Operation
- PLL_LOCKED passes through a 2-FF synchronizer to produce lock_s.
- While RST=1: state=S_PLL_RST, PLL_RST=1, RST_OUT all ones, READY=0, FAULT=0, LOCK_LOSS_CNT=0, all counters 0.
- S_PLL_RST: PLL_RST=1 for PLL_RST_CYCLES cycles, then go to S_WAIT_LOCK. Clear the timeout counter on entry.
- S_WAIT_LOCK: PLL_RST=0.
  - lock_s=1: go to S_FILTER.
  - Timeout counter reaches LOCK_TIMEOUT: increment retry.
  - If retry then equals MAX_RETRIES, go to S_FAULT; otherwise go to S_PLL_RST.
- S_FILTER: counts consecutive lock_s=1 cycles.
  - lock_s=0: clear the count and return to S_WAIT_LOCK. The timeout counter keeps running.
  - Count reaches LOCK_FILTER_CYCLES: deassert RST_OUT[0] and go to S_RELEASE.
- S_RELEASE: deassert RST_OUT[k] STAGE_DELAY cycles after RST_OUT[k-1]. READY rises in the same cycle the last stage deasserts. Retry clears and the state becomes S_RUN.
- S_RUN: hold.
- Lock loss (lock_s=0 in S_RELEASE or S_RUN):
  - Next cycle: all RST_OUT=1, READY=0, PLL_RST=1.
  - LOCK_LOSS_CNT increments, saturating at 255.
  - Retry clears; go to S_PLL_RST.
- S_FAULT: PLL_RST=1, RST_OUT all ones, READY=0, FAULT=1. Exits only on RST.
- NUM_STAGES=1: READY rises together with RST_OUT[0].
- Counter widths are $clog2(max value + 1). Comparisons are made on the registered count; counters never wrap.

## Timing
- Lock synchronizer latency: 2 cycles.
- PLL_RST falls PLL_RST_CYCLES cycles after the entry edge to S_PLL_RST.
- PLL_LOCKED rising at edge t with lock stable:
  - lock_s=1 at t+2.
  - RST_OUT[0] falls at t+2+LOCK_FILTER_CYCLES.
  - RST_OUT[k] falls at t+2+LOCK_FILTER_CYCLES+k·STAGE_DELAY.
- Lock drop at edge t: all RST_OUT reassert and READY falls at t+3, following the 2-cycle synchronizer.
- All outputs are registered; there are no combinational input-to-output paths.
- Simultaneous timeout and lock_s=1 in S_WAIT_LOCK: lock wins (go to S_FILTER).
- RST mid-sequence: all outputs return to their reset values in the next cycle, including FAULT and LOCK_LOSS_CNT.

## Configuration
- CLK_RST_SEQ_STATS_EN defined: the LOCK_LOSS_CNT counter is implemented as above.
- CLK_RST_SEQ_STATS_EN undefined: LOCK_LOSS_CNT is tied to 0 and no counter logic is built. All other behaviour is identical.

## Structure
- Shared package clk_rst_pkg holds:
  - the seq_state_t enum (S_PLL_RST, S_WAIT_LOCK, S_FILTER, S_RELEASE, S_RUN, S_FAULT);
  - the LOSS_CNT_W=8 constant.
- Sub-module lock_sync: 2-FF synchronizer with a parameterized reset value of 0.
- Everything else lives in one FSM with its counters.

## Test plan
Parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT=50, LOCK_FILTER_CYCLES=8, STAGE_DELAY=5, NUM_STAGES=3, MAX_RETRIES=2.
- Nominal bring-up: release RST, raise PLL_LOCKED at t=20 -> PLL_RST low from cycle 4; RST_OUT[0/1/2] fall at t+10/t+15/t+20; READY=1 at t+20.
- Filter glitch: PLL_LOCKED high 5 cycles, low 1 cycle, then high at t -> no RST_OUT release until t+10; READY at t+20.
- Timeout retry: PLL_LOCKED held low -> PLL_RST re-pulses for 4 cycles after 50 cycles in S_WAIT_LOCK. After the second timeout FAULT=1, PLL_RST=1, RST_OUT=3'b111. RST clears FAULT.
- Lock loss in S_RUN: drop PLL_LOCKED at t -> RST_OUT=3'b111, READY=0 at t+3; LOCK_LOSS_CNT=1; the sequence repeats once lock returns.
- Lock loss in S_RELEASE: drop lock after RST_OUT[0] falls -> all stages reassert; LOCK_LOSS_CNT increments.
- Saturation: apply 300 lock losses -> LOCK_LOSS_CNT=255. Repeat with CLK_RST_SEQ_STATS_EN undefined -> LOCK_LOSS_CNT=0.
